// File: rtl/nn_zoom_pkg.sv
// nn_zoom_pkg
//   Shared definitions for the nearest-neighbour zoom engine: the controller
//   state encoding, the mode constants and the legal source-RAM read latency
//   range.
package nn_zoom_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      RD,
      WAIT,
      WR,
      DONE
   } state_t;

   localparam logic MODE_IN  = 1'b0;   // zoom-in: replicate each source pixel F x F
   localparam logic MODE_OUT = 1'b1;   // zoom-out: keep every F-th pixel in X and Y

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 3;

endpackage

// File: rtl/nn_scan_counter.sv
// nn_scan_counter
//   Two-dimensional raster counter, X fastest, with limits supplied at run
//   time. The counter wraps back to (0,0) when stepped on its last position.
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   clear           force the position back to (0,0)
//   step            advance one position in raster order
//   lim_x, lim_y    number of positions in X and Y (both >= 1)
//   x, y            current position
//   wrap_x          current X is the last of its row
//   last            current position is the final one of the raster
module nn_scan_counter
#(
   parameter int W = 8
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         step,
   input  logic [W-1:0] lim_x,
   input  logic [W-1:0] lim_y,
   output logic [W-1:0] x,
   output logic [W-1:0] y,
   output logic         wrap_x,
   output logic         last
);

   always_comb begin
      wrap_x = (x == lim_x - W'(1));
      last   = wrap_x && (y == lim_y - W'(1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x <= '0;
         y <= '0;
      end else if (clear) begin
         x <= '0;
         y <= '0;
      end else if (step) begin
         if (wrap_x) begin
            x <= '0;
            y <= last ? '0 : y + W'(1);
         end else begin
            x <= x + W'(1);
         end
      end
   end

endmodule

// File: rtl/nn_zoom_engine.sv
// nn_zoom_engine
//   Nearest-neighbour scaler between the source and destination frame RAMs.
//   Zoom-in reads a (DST_W>>k) x (DST_H>>k) window at (offset_x, offset_y)
//   and writes every pixel F x F times; zoom-out reads every F-th pixel and
//   writes it once. One source pixel is handled per RD / WAIT / WR round.
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   start                     job request, sampled only in IDLE
//   mode, scale_log2          MODE_IN / MODE_OUT, factor F = 1 << scale_log2
//   offset_x, offset_y        source window origin (zoom-in only)
//   pixel_data                source RAM read data, RD_LAT cycles after rd_address
//   rd_address                source RAM address (registered)
//   wr_address, wr_data, wren destination RAM write port (registered)
//   busy, done, err           job status; err qualifies done for rejected jobs
module nn_zoom_engine
   import nn_zoom_pkg::*;
#(
   parameter int SRC_W     = 320,
   parameter int SRC_H     = 240,
   parameter int DST_W     = 320,
   parameter int DST_H     = 240,
   parameter int PIX_W     = 8,
   parameter int ADDR_W    = 17,
   parameter int MAX_SHIFT = 2,
   parameter int RD_LAT    = 1
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic [1:0]        scale_log2,
   input  logic [8:0]        offset_x,
   input  logic [7:0]        offset_y,
   input  logic [PIX_W-1:0]  pixel_data,
   output logic [ADDR_W-1:0] rd_address,
   output logic [ADDR_W-1:0] wr_address,
   output logic [PIX_W-1:0]  wr_data,
   output logic              wren,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int CNT_W  = $clog2(((DST_W > DST_H) ? DST_W : DST_H) + 1);
   localparam int REP_W  = $clog2((1 << MAX_SHIFT) + 1);
   localparam int WAIT_W = $clog2(RD_LAT_MAX);

   localparam logic [31:0] SRC_W_U     = 32'(SRC_W);
   localparam logic [31:0] SRC_H_U     = 32'(SRC_H);
   localparam logic [31:0] DST_W_U     = 32'(DST_W);
   localparam logic [31:0] DST_H_U     = 32'(DST_H);
   localparam logic [31:0] MAX_SHIFT_U = 32'(MAX_SHIFT);
   localparam logic [WAIT_W-1:0] LAT_LAST = WAIT_W'(RD_LAT - 1);

   state_t state;

   // Job configuration captured on acceptance.
   logic        cfg_mode;
   logic [1:0]  cfg_k;
   logic [8:0]  cfg_ox;
   logic [7:0]  cfg_oy;

   logic [WAIT_W-1:0] wait_cnt;

   logic [CNT_W-1:0]  pix_x, pix_y, pix_lim_x, pix_lim_y;
   logic [REP_W-1:0]  rep_x, rep_y, rep_lim;
   logic              pix_wrap, pix_last, rep_wrap, rep_last;
   logic              scan_clear, pix_step, rep_step;

   logic [31:0]       win_w, win_h;
   logic              cfg_ok;
   logic [CNT_W-1:0]  sx, sy;
   logic [REP_W-1:0]  rx, ry;
   logic [ADDR_W-1:0] rd_next, wr_next;

   assign scan_clear = (state == IDLE) && start;
   assign rep_step   = (state == WR);
   assign pix_step   = (state == WR) && rep_last;

   nn_scan_counter #(.W(CNT_W)) u_pix_scan (
      .clk    (clk),
      .rst    (rst),
      .clear  (scan_clear),
      .step   (pix_step),
      .lim_x  (pix_lim_x),
      .lim_y  (pix_lim_y),
      .x      (pix_x),
      .y      (pix_y),
      .wrap_x (pix_wrap),
      .last   (pix_last)
   );

   nn_scan_counter #(.W(REP_W)) u_rep_scan (
      .clk    (clk),
      .rst    (rst),
      .clear  (scan_clear),
      .step   (rep_step),
      .lim_x  (rep_lim),
      .lim_y  (rep_lim),
      .x      (rep_x),
      .y      (rep_y),
      .wrap_x (rep_wrap),
      .last   (rep_last)
   );

   // Window size, validity and scan limits, all from the latched config.
   always_comb begin
      win_w  = DST_W_U >> cfg_k;
      win_h  = DST_H_U >> cfg_k;
      cfg_ok = (32'(cfg_k) <= MAX_SHIFT_U) &&
               ((cfg_mode == MODE_OUT) ||
                ((32'(cfg_ox) + win_w <= SRC_W_U) && (32'(cfg_oy) + win_h <= SRC_H_U)));
      pix_lim_x = CNT_W'(win_w);
      pix_lim_y = CNT_W'(win_h);
      rep_lim   = (cfg_mode == MODE_IN) ? REP_W'(32'd1 << cfg_k) : REP_W'(1);
   end

   // Addresses are registered on the edge that enters RD / the next WR
   // cycle, so while in WR they are formed from the position the counters
   // are about to step to rather than the current one.
   always_comb begin
      if (state == WR) begin
         sx = pix_wrap ? '0 : pix_x + CNT_W'(1);
         sy = pix_wrap ? pix_y + CNT_W'(1) : pix_y;
         rx = rep_wrap ? '0 : rep_x + REP_W'(1);
         ry = rep_wrap ? rep_y + REP_W'(1) : rep_y;
      end else begin
         sx = pix_x;
         sy = pix_y;
         rx = rep_x;
         ry = rep_y;
      end

      if (cfg_mode == MODE_IN) begin
         rd_next = ADDR_W'((32'(cfg_oy) + 32'(sy)) * SRC_W_U + 32'(cfg_ox) + 32'(sx));
         wr_next = ADDR_W'(((32'(pix_y) << cfg_k) + 32'(ry)) * DST_W_U +
                           (32'(pix_x) << cfg_k) + 32'(rx));
      end else begin
         rd_next = ADDR_W'((32'(sy) << cfg_k) * SRC_W_U + (32'(sx) << cfg_k));
         wr_next = ADDR_W'(32'(pix_y) * DST_W_U + 32'(pix_x));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cfg_mode   <= MODE_IN;
         cfg_k      <= '0;
         cfg_ox     <= '0;
         cfg_oy     <= '0;
         wait_cnt   <= '0;
         rd_address <= '0;
         wr_address <= '0;
         wr_data    <= '0;
         wren       <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         wren <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  cfg_mode <= mode;
                  cfg_k    <= scale_log2;
                  cfg_ox   <= offset_x;
                  cfg_oy   <= offset_y;
                  busy     <= 1'b1;
                  state    <= CHECK;
               end
            end
            CHECK: begin
               if (!cfg_ok) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  err   <= 1'b1;
                  state <= DONE;
               end else begin
                  rd_address <= rd_next;
                  state      <= RD;
               end
            end
            RD: begin
               wait_cnt <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               if (wait_cnt == LAT_LAST) begin
                  wr_data    <= pixel_data;
                  wr_address <= wr_next;
                  wren       <= 1'b1;
                  state      <= WR;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            WR: begin
               if (rep_last) begin
                  if (pix_last) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     rd_address <= rd_next;
                     state      <= RD;
                  end
               end else begin
                  // Back-to-back replicated writes; wr_data stays put.
                  wr_address <= wr_next;
                  wren       <= 1'b1;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nn_zoom_engine.sv
// tb_nn_zoom_engine
//   Two engines on an 8x8 frame pair: instance 0 with a 1-cycle source RAM,
//   instance 1 with a 3-cycle source RAM. Source word = address. Expected
//   destination contents are derived per destination pixel (gather) from the
//   scaling rules.
module tb_nn_zoom_engine;

   localparam int W  = 8;
   localparam int H  = 8;
   localparam int AW = 6;
   localparam int PW = 8;
   localparam int MS = 2;
   localparam logic [7:0] POISON    = 8'hEE;   // stands in for unknown read data
   localparam logic [7:0] UNTOUCHED = 8'hDD;   // destination never written

   logic           clk = 1'b0;
   logic           rst;
   logic           mode;
   logic [1:0]     scale_log2;
   logic [8:0]     offset_x;
   logic [7:0]     offset_y;
   logic           start      [2];
   logic [PW-1:0]  pixel_data [2];
   logic [AW-1:0]  rd_address [2];
   logic [AW-1:0]  wr_address [2];
   logic [PW-1:0]  wr_data    [2];
   logic           wren [2];
   logic           busy [2];
   logic           done [2];
   logic           err  [2];

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      nn_zoom_engine #(
         .SRC_W(W), .SRC_H(H), .DST_W(W), .DST_H(H), .PIX_W(PW),
         .ADDR_W(AW), .MAX_SHIFT(MS), .RD_LAT((gi == 0) ? 1 : 3)
      ) u_dut (
         .clk        (clk),
         .rst        (rst),
         .start      (start[gi]),
         .mode       (mode),
         .scale_log2 (scale_log2),
         .offset_x   (offset_x),
         .offset_y   (offset_y),
         .pixel_data (pixel_data[gi]),
         .rd_address (rd_address[gi]),
         .wr_address (wr_address[gi]),
         .wr_data    (wr_data[gi]),
         .wren       (wren[gi]),
         .busy       (busy[gi]),
         .done       (done[gi]),
         .err        (err[gi])
      );
   end

   function automatic int lat_of(input int g);
      return (g == 0) ? 1 : 3;
   endfunction

   // Source RAM: word = address, valid only once the address has been held
   // for the full latency; otherwise the poison marker is returned.
   logic [AW-1:0] pipe [2][3];
   always @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         pipe[g][0] <= rd_address[g];
         pipe[g][1] <= pipe[g][0];
         pipe[g][2] <= pipe[g][1];
      end
   end
   always_comb begin
      for (int g = 0; g < 2; g++) begin
         pixel_data[g] = {2'b00, pipe[g][0]};
         if (pipe[g][0] != rd_address[g]) pixel_data[g] = POISON;
         for (int i = 1; i < 3; i++)
            if (i < lat_of(g) && pipe[g][i] != pipe[g][0]) pixel_data[g] = POISON;
      end
   end

   // Destination RAM and write/protocol monitor.
   logic          clr [2];
   logic [7:0]    dst [2][W*H];
   int            wr_cnt     [2];
   int            poison_cnt [2];
   int            proto_bad  [2] = '{0, 0};
   logic [AW-1:0] last_wa [2];
   logic [7:0]    last_wd [2];
   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if ((busy[g] && done[g]) || (err[g] && !done[g])) proto_bad[g] <= proto_bad[g] + 1;
         if (clr[g]) begin
            for (int a = 0; a < W*H; a++) dst[g][a] <= UNTOUCHED;
            wr_cnt[g]     <= 0;
            poison_cnt[g] <= 0;
         end else if (wren[g]) begin
            dst[g][wr_address[g]] <= wr_data[g];
            wr_cnt[g]  <= wr_cnt[g] + 1;
            last_wa[g] <= wr_address[g];
            last_wd[g] <= wr_data[g];
            if (wr_data[g] == POISON) poison_cnt[g] <= poison_cnt[g] + 1;
         end
      end
   end

   task automatic check(input string tag, input int got, input int want);
      vectors++;
      assert (got === want) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, want);
      end
   endtask

   function automatic bit job_ok(input int m, input int k, input int ox, input int oy);
      if (k > MS) return 1'b0;
      if (m == 1) return 1'b1;
      return (ox + W / (1 << k) <= W) && (oy + H / (1 << k) <= H);
   endfunction

   // Value expected at destination address a after a job.
   function automatic int exp_pix(input int m, input int k, input int ox, input int oy, input int a);
      int f, x, y;
      f = 1 << k;
      x = a % W;
      y = a / W;
      if (m == 0) return (oy + y / f) * W + ox + x / f;
      if (x < W / f && y < H / f) return (y * f) * W + x * f;
      return int'(UNTOUCHED);
   endfunction

   task automatic run_job(input int g, input int m, input int k, input int ox, input int oy,
                          input bit poke);
      int  f, n_pix, per, want_lat, want_wr, e, lat, got_err;
      bit  ok;
      string id;
      ok       = job_ok(m, k, ox, oy);
      f        = 1 << k;
      n_pix    = (W / f) * (H / f);
      per      = 1 + lat_of(g) + ((m == 0) ? f * f : 1);
      want_lat = ok ? 1 + n_pix * per : 1;
      want_wr  = !ok ? 0 : (m == 0) ? W * H : n_pix;
      id       = $sformatf("g%0d m%0d k%0d o(%0d,%0d)", g, m, k, ox, oy);

      clr[g] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      clr[g]     = 1'b0;
      mode       = m[0];
      scale_log2 = k[1:0];
      offset_x   = 9'(ox);
      offset_y   = 8'(oy);
      start[g]   = 1'b1;
      @(negedge clk);
      start[g]   = 1'b0;
      check({id, " busy_in_check"}, int'(busy[g]), 1);
      // Disturb the inputs: the job must run from the latched copy.
      mode       = ~mode;
      scale_log2 = ~scale_log2;
      offset_x   = offset_x + 9'd3;
      offset_y   = offset_y + 8'd5;

      e = 0;
      lat = -1;
      got_err = -1;
      while (e < 3000 && lat < 0) begin
         @(negedge clk);
         e++;
         if (poke && e == 10) start[g] = 1'b1;
         if (poke && e == 11) start[g] = 1'b0;
         if (e == 1 && ok)
            check({id, " first_rd"}, int'(rd_address[g]), (m == 0) ? oy * W + ox : 0);
         if (done[g]) begin
            lat     = e;
            got_err = int'(err[g]);
         end
      end
      start[g] = 1'b0;
      check({id, " done_latency"}, lat, want_lat);
      check({id, " err"}, got_err, ok ? 0 : 1);
      @(negedge clk);
      check({id, " wren_count"}, wr_cnt[g], want_wr);
      check({id, " poison_writes"}, poison_cnt[g], 0);
      for (int a = 0; a < W * H; a++)
         check($sformatf("%s dst[%0d]", id, a), int'(dst[g][a]),
               ok ? exp_pix(m, k, ox, oy, a) : int'(UNTOUCHED));
      if (ok) begin
         int la;
         la = (m == 0) ? W * H - 1 : (H / f - 1) * W + (W / f - 1);
         check({id, " last_wr_addr"}, int'(last_wa[g]), la);
         check({id, " last_wr_data"}, int'(last_wd[g]), exp_pix(m, k, ox, oy, la));
      end
   endtask

   initial begin
      int n;
      rst        = 1'b1;
      start      = '{1'b0, 1'b0};
      clr        = '{1'b0, 1'b0};
      mode       = 1'b0;
      scale_log2 = 2'd0;
      offset_x   = 9'd0;
      offset_y   = 8'd0;
      repeat (3) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         check($sformatf("g%0d reset rd_address", g), int'(rd_address[g]), 0);
         check($sformatf("g%0d reset wr_address", g), int'(wr_address[g]), 0);
         check($sformatf("g%0d reset wr_data", g), int'(wr_data[g]), 0);
         check($sformatf("g%0d reset wren", g), int'(wren[g]), 0);
         check($sformatf("g%0d reset busy", g), int'(busy[g]), 0);
         check($sformatf("g%0d reset done", g), int'(done[g]), 0);
         check($sformatf("g%0d reset err", g), int'(err[g]), 0);
      end
      rst = 1'b0;
      @(negedge clk);

      run_job(0, 0, 1, 2, 1, 1'b0);   // zoom-in k=1, window at (2,1)
      run_job(0, 1, 1, 0, 0, 1'b0);   // zoom-out k=1
      run_job(0, 0, 1, 5, 0, 1'b0);   // window overruns source in X
      run_job(0, 0, 3, 0, 0, 1'b0);   // scale beyond MAX_SHIFT
      run_job(1, 0, 2, 1, 1, 1'b0);   // k=2 zoom-in, 3-cycle RAM
      run_job(1, 1, 2, 0, 0, 1'b0);   // k=2 zoom-out, 3-cycle RAM
      run_job(0, 0, 1, 0, 0, 1'b1);   // start pulsed mid-job

      // Reset in the middle of a write burst.
      mode       = 1'b0;
      scale_log2 = 2'd1;
      offset_x   = 9'd0;
      offset_y   = 8'd0;
      start[0]   = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      n = 0;
      while (!wren[0] && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("wait_for_wren", int'(wren[0]), 1);
      #2 rst = 1'b1;
      #1;
      check("async_rst wren", int'(wren[0]), 0);
      check("async_rst busy", int'(busy[0]), 0);
      check("async_rst done", int'(done[0]), 0);
      @(negedge clk);
      rst = 1'b0;
      run_job(0, 0, 0, 0, 0, 1'b0);   // 1:1 copy after reset

      repeat (12) begin
         run_job(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
                 int'($urandom_range(0, 6)), 1'b0);
      end

      check("g0 busy_done_err_protocol", proto_bad[0], 0);
      check("g1 busy_done_err_protocol", proto_bad[1], 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/nn_zoom_engine.md
# nn_zoom_engine

Parametrised nearest-neighbour scaling engine for the zoom datapath: reads pixels from the source frame RAM through a synchronous read port and writes the scaled result into the destination frame RAM. Supports power-of-two zoom-in (pixel replication, F×F writes per source pixel) and zoom-out (decimation, one write per kept pixel), with a programmable source window offset and a configurable RAM read latency. It sits between the control/register block, which drives `start`, mode, scale and offsets, and the two frame buffers.

## Interface
- `SRC_W`, 320, source frame width in pixels
- `SRC_H`, 240, source frame height
- `DST_W`, 320, destination frame width; multiple of `1<<MAX_SHIFT`
- `DST_H`, 240, destination frame height; multiple of `1<<MAX_SHIFT`
- `PIX_W`, 8, pixel width
- `ADDR_W`, 17, RAM address width; must hold `max(SRC_W*SRC_H, DST_W*DST_H)-1`
- `MAX_SHIFT`, 2, largest legal `scale_log2`
- `RD_LAT`, 1, source RAM read latency in cycles (1..3)
- `clk`  in  1  sole clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle request; sampled only in IDLE
- `mode`  in  1  0 = zoom-in (replicate), 1 = zoom-out (decimate)
- `scale_log2`  in  2  factor F = 1<<scale_log2
- `offset_x`  in  9  source window X origin (zoom-in only)
- `offset_y`  in  8  source window Y origin (zoom-in only)
- `pixel_data`  in  PIX_W  source RAM read data
- `rd_address`  out  ADDR_W  source RAM address, registered
- `wr_address`  out  ADDR_W  destination RAM address, registered
- `wr_data`  out  PIX_W  destination write data, registered
- `wren`  out  1  destination write enable, registered
- `busy`  out  1  high from the cycle after an accepted `start` until DONE
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  qualifies `done`: configuration rejected, no writes issued

## Operation
- On an accepted `start`, latch `mode`, `scale_log2`, `offset_x` and `offset_y`. Later input changes are ignored until the next job.
- Validation runs in the cycle after acceptance. The job fails if:
  - `scale_log2 > MAX_SHIFT`, or
  - in zoom-in, `offset_x + (DST_W>>k) > SRC_W` or `offset_y + (DST_H>>k) > SRC_H`, where k = `scale_log2`.
  - On failure, go to DONE with `err=1` and issue no `wren`.
- Zoom-in scan:
  - Scan the window xs in 0..(DST_W>>k)-1 and ys in 0..(DST_H>>k)-1 in raster order, X fastest.
  - Read address = `(offset_y+ys)*SRC_W + offset_x+xs`.
  - Write the captured pixel to `((ys<<k)+dy)*DST_W + (xs<<k)+dx` for dy in 0..F-1 (outer) and dx in 0..F-1 (inner).
- Zoom-out scan:
  - Scan xo in 0..(DST_W>>k)-1 and yo in 0..(DST_H>>k)-1.
  - Read `(yo<<k)*SRC_W + (xo<<k)` and write once to `yo*DST_W + xo`.
  - Offsets are ignored. Destination pixels outside the scanned region are left untouched.
- k=0 in either mode performs a 1:1 copy.
- All address arithmetic is unsigned and carried at full precision internally, then truncated to ADDR_W. Legal parameters never overflow.
- States and transitions:
  - IDLE: `start` → CHECK.
  - CHECK: invalid → DONE (err); valid → RD.
  - RD: 1 cycle → WAIT.
  - WAIT: RD_LAT cycles; `pixel_data` is captured on the last WAIT edge → WR.
  - WR: F² cycles (zoom-in) or 1 cycle (zoom-out). Then → RD for the next pixel, or → DONE after the last pixel.
  - DONE: 1 cycle → IDLE.
- `rst` asserted at any time, including mid-job, returns to IDLE immediately with all outputs at reset values. The partial destination contents are not restored.

## Timing
- Reset values: `rd_address`=0, `wr_address`=0, `wr_data`=0, `wren`=0, `busy`=0, `done`=0, `err`=0.
- `rd_address` is updated on the edge that enters RD and held through WAIT.
- `wren` is high exactly during WR cycles, with `wr_address`/`wr_data` valid in the same cycles. No idle gap occurs between consecutive writes of one source pixel.
- Cycles per source pixel: 1 + RD_LAT + F² (zoom-in), or 1 + RD_LAT + 1 (zoom-out).
- Job latency: 1 (CHECK) + N_pixels × per-pixel cycles, then `done` in the next cycle.
- `start` while `busy` is ignored. `start` arriving in the DONE cycle is ignored. `start` arriving on the cycle IDLE is re-entered is accepted.
- `busy` and `done` are never high together. `err` is high only alongside `done`.

## Structure
- Package `nn_zoom_pkg`: state enum (IDLE, CHECK, RD, WAIT, WR, DONE), mode constants `MODE_IN`/`MODE_OUT`, and the `RD_LAT` range constants.
- Sub-module `nn_scan_counter`: a parametrised 2-D raster counter with run-time limits, `step`, `wrap_x` and `last` outputs. It is instantiated twice: once for the pixel (xs, ys) scan and once for the replication (dx, dy) scan.

## Test plan
Unless noted, the bench uses SRC_W=DST_W=8, SRC_H=DST_H=8, MAX_SHIFT=2, RD_LAT=1, with source RAM word = address.
- Zoom-in, k=1, offset (2,1) → 16 reads, 64 writes.
  - First read address 10.
  - Writes to 0, 1, 8, 9 carry data 10.
  - Last write: address 63, data 37.
  - `done` arrives 1+16×6 cycles after acceptance.
- Zoom-out, k=1 → 16 writes.
  - Destination 1 gets 2; destination 8 gets 16; destination 27 gets 54.
  - Destination 4 is never written.
- Error cases:
  - k=1, offset_x=5 → `done`=`err`=1 two cycles after `start`, zero `wren`.
  - `scale_log2`=3 → same response.
- Rerun the k=2 zoom-in test with RD_LAT=3 → each write carries the word at the read address.
  - Per-pixel period = 20 cycles.
  - The bench RAM returns X before latency expires and checks that X is never written.
- Pulse `start` mid-job → ignored, write count unchanged. Assert `rst` during WR → `wren`, `busy` and `done` drop asynchronously; a fresh `start` completes a correct k=0 copy of 64 writes.
